// File: rtl/text_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_line_fetch                                              |
// | Description : Text-mode scanline fetcher. For each character column it     |
// |               reads the character code, then the font byte for the        |
// |               current scanline. It then shifts the font byte out MSB-first |
// |               as one pixel per clock. The pixel stream for a line has no   |
// |               gaps.                                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk              sole clock, rising edge
//   reset_n          synchronous active-low reset
//   line_start       one-cycle pulse starting a scanline (restarts if active)
//   row[8:0]         display scanline, sampled with line_start
//   mem_read_addr    video memory read address (character, then font)
//   mem_read_enable  video memory read strobe
//   mem_read_data    memory data, valid the cycle after the address
//   pixel_valid      pixel_on carries a pixel this cycle
//   pixel_on         foreground (1) / background (0), 0 when not valid
//   line_done        one-cycle pulse after the last pixel of a line
// Optional feature (macro TEXT_CURSOR_EN):
//   cursor_col[6:0], cursor_row[5:0] inputs; the cursor inverts all 8
//   pixels of the cursor cell on the bottom scanline (row[2:0]==7) of the
//   cursor character row.
module text_line_fetch #(
  parameter int          COLUMNS       = 80,
  parameter int          ADDRESS_WIDTH = 12,
  parameter int unsigned FONT_BASE     = 12'h800
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     line_start,
  input  logic [8:0]               row,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  output logic                     mem_read_enable,
  input  logic [7:0]               mem_read_data,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]               cursor_col,
  input  logic [5:0]               cursor_row,
`endif
  output logic                     pixel_valid,
  output logic                     pixel_on,
  output logic                     line_done
);

  // cnt counts cycles since the line_start sample cycle, minus one:
  // cnt = 8k + 0 -> char fetch of column k
  // cnt = 8k + 1 -> font fetch of column k
  // cnt = 8k + 2 -> font byte captured
  // The pixels run from cnt 3 to 8*COLUMNS+2. line_done is at cnt 8*COLUMNS+3.
  localparam int                CNT_W     = $clog2(8 * COLUMNS + 4);
  localparam logic [CNT_W-1:0]  FETCH_END = CNT_W'(8 * COLUMNS);
  localparam logic [CNT_W-1:0]  DONE_CNT  = CNT_W'(8 * COLUMNS + 3);
  localparam logic [CNT_W-1:0]  PIX_START = CNT_W'(3);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [8:0]       row_q,   row_d;
  // The shift register also serves as the pattern buffer. The next font
  // byte is captured in the same cycle that the last bit of the previous
  // byte is shown, so a separate buffer would never hold distinct data.
  logic [7:0]       shift_q, shift_d;

  logic             active;
  logic             fetching;
  logic             pix_active;
  logic             line_end;
  logic [2:0]       phase;
  logic             cursor_hit;

  assign active     = (state_q == S_ACTIVE);
  assign fetching   = active && (cnt_q < FETCH_END);
  assign pix_active = active && (cnt_q >= PIX_START) && (cnt_q < DONE_CNT);
  assign line_end   = active && (cnt_q == DONE_CNT);
  assign phase      = cnt_q[2:0];

`ifdef TEXT_CURSOR_EN
  assign cursor_hit = (row_q[2:0] == 3'd7) && (row_q[8:3] == cursor_row) &&
                      ((32'(cnt_q - PIX_START) >> 3) == 32'(cursor_col));
`else
  assign cursor_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    shift_d = shift_q;
    if (line_start) begin
      // Also aborts a line in progress; its line_done never fires.
      state_d = S_ACTIVE;
      cnt_d   = '0;
      row_d   = row;
      shift_d = '0;
    end else if (active) begin
      if (line_end) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Load has priority. It replaces bit 0 of the previous byte, which is
      // on pixel_on this cycle.
      if (fetching && (phase == 3'd2)) begin
        shift_d = mem_read_data;
      end else if (pix_active) begin
        shift_d = {shift_q[6:0], 1'b0};
      end
    end
  end

  // Output logic. The font address depends on mem_read_data in the same
  // cycle, so the address path is combinational.
  always_comb begin
    mem_read_addr   = '0;
    mem_read_enable = 1'b0;
    if (fetching && (phase == 3'd0)) begin
      mem_read_enable = 1'b1;
      mem_read_addr   = ADDRESS_WIDTH'(int'(row_q[8:3]) * COLUMNS +
                                      int'(cnt_q[CNT_W-1:3]));
    end else if (fetching && (phase == 3'd1)) begin
      mem_read_enable = 1'b1;
      mem_read_addr   = ADDRESS_WIDTH'(FONT_BASE +
                                      32'(mem_read_data) * 32'd8 +
                                      32'(row_q[2:0]));
    end
    pixel_valid = pix_active;
    pixel_on    = pix_active && (shift_q[7] ^ cursor_hit);
    line_done   = line_end;
  end

endmodule
`default_nettype wire
